// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: single-clock AXI-Stream beat buffer between s01 (upstream)
// and m01 (downstream). It runs in cut-through mode, or in store-and-forward
// mode where beats are held back until a complete packet (through tlast) is
// stored. A full buffer also releases beats, so that a packet longer than the
// buffer cannot deadlock it. The read side is first-word-fall-through.
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,

    input  logic [DATA_WIDTH-1:0]         s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s01_axis_tstrb,
    input  logic                          s01_axis_tvalid,
    input  logic                          s01_axis_tlast,
    output logic                          s01_axis_tready,

    output logic [DATA_WIDTH-1:0]         m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       m01_axis_tstrb,
    output logic                          m01_axis_tvalid,
    output logic                          m01_axis_tlast,
    input  logic                          m01_axis_tready,

    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [$clog2(DEPTH):0]        pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage is deliberately left unreset; pointers and counts define validity.
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [SW-1:0]         mem_strb [DEPTH];
    logic                  mem_last [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ_q;
    logic [CW-1:0] pkt_q;

    logic push;
    logic pop;
    logic push_last;
    logic pop_last;
    logic rel_ok;

    // Ready looks only at registered fill level; a same-cycle pop never frees a slot.
    assign s01_axis_tready = !axis_areset && (occ_q != FULL_CNT);

    // Release: any stored beat in cut-through mode; in packet mode a complete
    // packet must be stored, or the buffer must be full.
    assign rel_ok = (occ_q != '0) &&
                    ((PACKET_MODE == 0) || (pkt_q != '0) || (occ_q == FULL_CNT));

    assign m01_axis_tvalid = !axis_areset && rel_ok;

    assign push      = s01_axis_tvalid && s01_axis_tready;
    assign pop       = m01_axis_tvalid && m01_axis_tready;
    assign push_last = push && s01_axis_tlast;
    assign pop_last  = pop && mem_last[rd_ptr];

    // Head entry is shown only while valid, otherwise the bus is driven to zero.
    assign m01_axis_tdata = m01_axis_tvalid ? mem_data[rd_ptr] : '0;
    assign m01_axis_tstrb = m01_axis_tvalid ? mem_strb[rd_ptr] : '0;
    assign m01_axis_tlast = m01_axis_tvalid ? mem_last[rd_ptr] : 1'b0;

    assign occupancy = occ_q;
    assign pkt_count = pkt_q;

    // Write the incoming beat at the write pointer.
    always_ff @(posedge axis_aclk) begin
        if (push) begin
            mem_data[wr_ptr] <= s01_axis_tdata;
            mem_strb[wr_ptr] <= s01_axis_tstrb;
            mem_last[wr_ptr] <= s01_axis_tlast;
        end
    end

    // Pointers advance on push/pop and wrap naturally at DEPTH.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Stored beat count; simultaneous push and pop cancel.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            occ_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CW'(1);
                2'b01:   occ_q <= occ_q - CW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Count of stored tlast beats, i.e. complete packets held in the buffer.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            pkt_q <= '0;
        end else begin
            case ({push_last, pop_last})
                2'b10:   pkt_q <= pkt_q + CW'(1);
                2'b01:   pkt_q <= pkt_q - CW'(1);
                default: pkt_q <= pkt_q;
            endcase
        end
    end

endmodule
